// File: rtl/keypad_lock_pkg.sv
// Shared types and key codes for the two-digit keypad lock.
// Used by keypad_lock_ctrl and key_edge_det.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam logic [1:0] DIG_NONE = 2'b00;
  localparam logic [1:0] DIG_1    = 2'b01;
  localparam logic [1:0] DIG_2    = 2'b10;

  // 2'b11 is an invalid keypad code and never counts as a digit.
  function automatic logic is_digit(input logic [1:0] code);
    return (code == DIG_1) || (code == DIG_2);
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Press detector: registers the raw keypad lines and flags a press only on the
// sample where a key goes from released to pressed, so held keys count once.
module key_edge_det
  import keypad_lock_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] button_2_1,
  input  logic       button_star,
  output logic       digit_vld,
  output logic [1:0] digit,
  output logic       star_vld
);

  logic [1:0] btn_q, btn_d;
  logic       star_q, star_d;

  always_comb begin
    btn_d  = button_2_1;
    star_d = button_star;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_q  <= DIG_NONE;
      star_q <= 1'b0;
    end else begin
      btn_q  <= btn_d;
      star_q <= star_d;
    end
  end

  always_comb begin
    star_vld  = button_star && !star_q;
    digit_vld = is_digit(button_2_1) && (btn_q == DIG_NONE);
    digit     = button_2_1;
  end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad door lock: first PW_LEN digits in OPEN set the password, digits plus '*'
// in LOCKED attempt an unlock. Define KEYPAD_LOCK_LOCKOUT_EN for the lockout feature.
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int PW_LEN = 2
`ifdef KEYPAD_LOCK_LOCKOUT_EN
  ,
  parameter int MAX_TRY     = 3,
  parameter int LOCKOUT_CYC = 16
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] button_2_1,
  input  logic       button_star,
  output logic       lock,
  output logic       open,
  output logic       led_red,
  output logic       led_green
);

  localparam int IDX_W = $clog2(PW_LEN + 1);

  logic       digit_vld, star_vld, take_digit, match;
  logic [1:0] digit;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [PW_LEN-1:0][1:0]   pw_q, pw_d;
  logic [PW_LEN-1:0][1:0]   entry_q, entry_d;
  logic                     ovf_q, ovf_d;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
  localparam int CNT_W = $clog2(LOCKOUT_CYC);
  logic [1:0]       fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
`endif

  key_edge_det u_edge (
    .clk         (clk),
    .n_rst       (n_rst),
    .button_2_1  (button_2_1),
    .button_star (button_star),
    .digit_vld   (digit_vld),
    .digit       (digit),
    .star_vld    (star_vld)
  );

  // A star in the same cycle as a digit takes priority.
  assign take_digit = digit_vld && !star_vld;
  assign match      = (idx_q == IDX_W'(PW_LEN)) && !ovf_q && (entry_q == pw_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_OPEN;
      idx_q   <= '0;
      pw_q    <= '0;
      entry_q <= '0;
      ovf_q   <= 1'b0;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
      fail_q  <= '0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pw_q    <= pw_d;
      entry_q <= entry_d;
      ovf_q   <= ovf_d;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pw_d    = pw_q;
    entry_d = entry_q;
    ovf_d   = ovf_q;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
`endif
    case (state_q)
      ST_OPEN: begin
        if (take_digit) begin
          for (int i = 0; i < PW_LEN; i++) begin
            if (idx_q == IDX_W'(i)) pw_d[i] = digit;
          end
          if (idx_q == IDX_W'(PW_LEN - 1)) begin
            state_d = ST_LOCKED;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (star_vld) begin
          idx_d   = '0;
          entry_d = '0;
          ovf_d   = 1'b0;
          if (match) state_d = ST_OPEN;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
          if (match) begin
            fail_d = '0;
          end else begin
            fail_d = fail_q + 2'd1;
            if (fail_q == 2'(MAX_TRY - 1)) begin
              state_d = ST_LOCKOUT;
              cnt_d   = '0;
              blink_d = 1'b1;
            end
          end
`endif
        end else if (take_digit) begin
          if (idx_q == IDX_W'(PW_LEN)) begin
            ovf_d = 1'b1;
          end else begin
            for (int i = 0; i < PW_LEN; i++) begin
              if (idx_q == IDX_W'(i)) entry_d[i] = digit;
            end
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef KEYPAD_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        blink_d = ~blink_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LOCKOUT_CYC - 1)) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    open      = (state_q == ST_OPEN);
    lock      = (state_q == ST_LOCKED) || (state_q == ST_LOCKOUT);
    led_green = open;
    led_red   = lock;
`ifdef KEYPAD_LOCK_LOCKOUT_EN
    if (state_q == ST_LOCKOUT) led_red = blink_q;
`endif
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: directed vector table, hand sequences for corner
// cases and random key traffic, all checked against a queue-based lock model.
module tb_keypad_lock_ctrl;

  localparam int PW_LEN      = 2;
  localparam int MAX_TRY     = 3;
  localparam int LOCKOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] button_2_1 = 2'b00;
  logic       button_star = 1'b0;
  logic       lock, open, led_red, led_green;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  keypad_lock_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .button_2_1  (button_2_1),
    .button_star (button_star),
    .lock        (lock),
    .open        (open),
    .led_red     (led_red),
    .led_green   (led_green)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=open 1=locked 2=lockout, password/entry as digit lists.
  int m_mode;
  int m_pw[$];
  int m_ent[$];
  int m_prev_btn, m_prev_star;
  int m_fail, m_left, m_blink;

  function automatic void model_reset();
    m_mode = 0; m_pw.delete(); m_ent.delete();
    m_prev_btn = 0; m_prev_star = 0;
    m_fail = 0; m_left = 0; m_blink = 0;
  endfunction

  function automatic bit entry_ok();
    if (m_ent.size() != m_pw.size()) return 1'b0;
    foreach (m_ent[i]) if (m_ent[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input int btn, input int star);
    bit dv, sv, ok;
    sv = (star != 0) && (m_prev_star == 0);
    dv = (btn == 1 || btn == 2) && (m_prev_btn == 0) && !sv;
    m_prev_btn = btn;
    m_prev_star = star;
    if (m_mode == 0) begin
      if (dv) begin
        m_pw.push_back(btn);
        if (m_pw.size() == PW_LEN) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (sv) begin
        ok = entry_ok();
        m_ent.delete();
        if (ok) begin
          m_mode = 0; m_pw.delete(); m_fail = 0;
        end else begin
`ifdef KEYPAD_LOCK_LOCKOUT_EN
          m_fail++;
          if (m_fail == MAX_TRY) begin
            m_mode = 2; m_left = LOCKOUT_CYC; m_blink = 1;
          end
`endif
        end
      end else if (dv) begin
        m_ent.push_back(btn);
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 1; m_fail = 0;
      end else begin
        m_blink = m_blink ^ 1;
      end
    end
  endfunction

  function automatic logic [3:0] model_out();
    logic l, o, r;
    o = (m_mode == 0);
    l = !o;
    r = (m_mode == 2) ? m_blink[0] : l;
    return {l, o, r, o};
  endfunction

  task automatic check4(input string name, input logic [3:0] exp);
    checks++;
    if ({lock, open, led_red, led_green} !== exp) begin
      errors++;
      $display("FAIL %s step=%0d lock/open/red/green got=%b required=%b",
               name, step_no, {lock, open, led_red, led_green}, exp);
    end
  endtask

  task automatic step(input logic [1:0] btn, input logic star);
    button_2_1 = btn;
    button_star = star;
    @(posedge clk);
    #1;
    step_no++;
    model_step(int'(btn), int'(star));
    check4("model", model_out());
    $display("step %0d btn=%b star=%b -> lock=%b open=%b red=%b green=%b",
             step_no, btn, star, lock, open, led_red, led_green);
  endtask

  task automatic do_reset();
    #2;
    n_rst = 1'b0;
    button_2_1 = 2'b00;
    button_star = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check4("reset", 4'b0101);
    n_rst = 1'b1;
  endtask

  task automatic press(input logic [1:0] btn);
    step(btn, 1'b0);
    step(2'b00, 1'b0);
  endtask

  task automatic star_press();
    step(2'b00, 1'b1);
    step(2'b00, 1'b0);
  endtask

  typedef struct {
    logic [1:0] btn;
    logic       star;
    logic       exp_lock;
    logic       exp_open;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] b, input logic s,
                              input logic l, input logic o);
    vec_t v;
    v.btn = b; v.star = s; v.exp_lock = l; v.exp_open = o;
    tbl.push_back(v);
  endfunction

  initial begin
    // Password 1,2 with a gap of idles, then unlock with 1,2,*
    add(2'b01, 0, 0, 1); add(2'b00, 0, 0, 1); add(2'b00, 0, 0, 1);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b01, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b00, 1, 0, 1); add(2'b00, 0, 0, 1);
    // Re-program to 2,2; wrong 1,2,* stays locked; 2,2,* opens
    add(2'b10, 0, 0, 1); add(2'b00, 0, 0, 1);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b01, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b00, 1, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b00, 1, 0, 1); add(2'b00, 0, 0, 1);
    // Held 2'b11 in OPEN stores nothing
    add(2'b11, 0, 0, 1); add(2'b11, 0, 0, 1); add(2'b00, 0, 0, 1);
    // Password 1,2 again
    add(2'b01, 0, 0, 1); add(2'b00, 0, 0, 1);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    // '*' alone, then long entry 1,2,2,* : both stay locked
    add(2'b00, 1, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b01, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b00, 1, 1, 0); add(2'b00, 0, 1, 0);
    // Digit 1 held five cycles counts once, then 2 and '*' opens
    for (int i = 0; i < 5; i++) add(2'b01, 0, 1, 0);
    add(2'b00, 0, 1, 0); add(2'b10, 0, 1, 0); add(2'b00, 0, 1, 0);
    add(2'b00, 1, 0, 1); add(2'b00, 1, 0, 1); add(2'b00, 0, 0, 1);

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].btn, tbl[i].star);
      check4("table", {tbl[i].exp_lock, tbl[i].exp_open, tbl[i].exp_lock, tbl[i].exp_open});
    end

    // Reset mid-entry after a single '1': password restarts from scratch
    do_reset();
    press(2'b01);
    do_reset();
    press(2'b10);
    check4("rst_mid_first", 4'b0101);
    press(2'b01);
    check4("rst_mid_locked", 4'b1010);
    press(2'b10); press(2'b01); star_press();
    check4("rst_mid_unlock", 4'b0101);

    // Digit and star together in OPEN: digit dropped
    step(2'b10, 1'b1);
    step(2'b00, 1'b0);
    press(2'b01);
    check4("star_wins", 4'b0101);
    press(2'b01);
    check4("star_wins_lock", 4'b1010);

`ifdef KEYPAD_LOCK_LOCKOUT_EN
    // Three failed attempts (password 1,1) enter lockout
    star_press(); star_press();
    step(2'b00, 1'b1);
    check4("lockout_enter", 4'b1010);
    step(2'b01, 1'b0);
    check4("lockout_blink", 4'b1000);
    for (int i = 0; i < 16; i++) step((i % 2 == 0) ? 2'b00 : 2'b01, 1'b0);
    check4("lockout_exit", 4'b1010);
    star_press();
    press(2'b01); press(2'b01); star_press();
    check4("lockout_unlock", 4'b0101);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0] b;
      logic s;
      b = ($urandom_range(0, 9) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
      s = ($urandom_range(0, 5) == 0);
      step(b, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
